brent_adder_pipe: RTL
=====================

Name: brent_adder_pipe

Overview:
- Parametrised, pipelined Brent-Kung parallel-prefix adder/subtractor with valid/ready handshake on input and output.
- Successor to the fixed 16-bit combinational Brent-Kung adder.
- Generalised in width and pipeline depth; adds subtract mode, carry-in, signed overflow flag and backpressure.
- Sits between operand-producing logic and any result consumer in the datapath labs.

Parameters:
- WIDTH, 16, operand/sum width; power of two, 4..64.
- PIPE_STAGES, 2, number of register stages through the prefix tree; 1..4; equals latency in cycles.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; ignored when sub=1.
- sub  input  1  0: a+b+cin; 1: a-b.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result.
- cout  output  1  carry-out; in subtract mode, 1 = no borrow (a >= b unsigned).
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Transfer occurs on a rising edge when valid and ready are both high, at input and at output independently.
- Datapath:
  - Generate/propagate from a and (sub ? ~b : b).
  - Carry-in = sub ? 1 : cin.
  - Brent-Kung prefix: log2(WIDTH) up-sweep levels, log2(WIDTH)-1 down-sweep levels.
  - Prefix levels are split across PIPE_STAGES registers as evenly as possible; the final stage register holds sum/cout/ovf.
  - ovf = carry into MSB XOR carry out of MSB.
  - Result bit-exact to (a + b' + c) mod 2^WIDTH.
- Latency: exactly PIPE_STAGES cycles from input handshake to out_valid when out_ready is held high.
- Throughput: one operation per cycle with no stalls.
- Per-stage valid bit v[k]; stage k loads when ready_k = !v[k] || ready_{k+1}; ready after the last stage = out_ready.
  - in_ready = ready_1, a combinational function of stage valids and out_ready.
  - Bubbles collapse under backpressure.
- Stall: while out_valid && !out_ready, sum/cout/ovf/out_valid hold stable. Up to PIPE_STAGES operations are buffered before in_ready drops.
- Ordering: results leave in acceptance order; no drop, no duplication.
- Reset:
  - All v[k] = 0; out_valid = 0; sum = 0; cout = 0; ovf = 0.
  - in_ready = 1 on the first cycle after reset deasserts.
  - Reset mid-stream discards all in-flight operations; no result emerges for them.
- Inputs are don't-care when in_valid = 0; stage data registers may hold stale values but outputs are masked only by out_valid (data outputs reset to 0).
- Simultaneous input and output handshakes in the same cycle are legal and do not stall.

Optional Feature:
- Macro BRENT_ADDER_SAT_EN.
- Defined: on signed overflow, sum saturates to the signed extreme: 2^(WIDTH-1)-1 if the true result is positive, -2^(WIDTH-1) if negative. ovf is still asserted; cout is unchanged.
- Undefined: sum wraps modulo 2^WIDTH; no saturation logic is instantiated.

Test Plan (WIDTH=16, PIPE_STAGES=2 unless stated):
- a=32767, b=64, sub=0, cin=0, out_ready=1 -> 2 cycles later out_valid=1, sum=32831, cout=0, ovf=1; with BRENT_ADDER_SAT_EN, sum=32767, ovf=1.
- a=65535, b=1, cin=0 -> sum=0, cout=1, ovf=0; a=0, b=0, cin=1 -> sum=1, cout=0.
- sub=1, a=5, b=7 -> sum=65534, cout=0, ovf=0; sub=1, a=32768, b=1 -> sum=32767, cout=1, ovf=1.
- Back-to-back stream 16+4, 128+16384, 256+32, 2048+4096 with out_ready=0 for cycles 1-4:
  - in_ready drops after 2 accepts.
  - After out_ready=1, results 20, 16512, 288, 6144 appear in order with no gaps.
- Reset asserted for 1 cycle with 2 operations in flight -> out_valid=0 next cycle, no stale result ever emitted, in_ready=1.
- WIDTH=32, PIPE_STAGES=4: a=0xFFFFFFFF, b=1 -> sum=0, cout=1 after exactly 4 cycles; 1000 random vectors match the reference model with random out_ready.

Source files
------------

// File: rtl/brent_adder_pipe.sv
// brent_adder_pipe: pipelined Brent-Kung prefix adder/subtractor with
// valid/ready handshake on both sides.
//   clk, reset           : rising-edge clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (in_ready is combinational)
//   a, b, cin, sub       : operands; sub=1 computes a-b and ignores cin
//   out_valid / out_ready: result handshake
//   sum, cout, ovf       : result, carry-out (no-borrow when sub=1), signed overflow
// Optional: define BRENT_ADDER_SAT_EN to saturate sum on signed overflow.
module brent_adder_pipe #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned PIPE_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned LOGW   = $clog2(WIDTH);
  localparam int unsigned LEVELS = 2 * LOGW - 1;
  localparam int unsigned NMID   = (PIPE_STAGES > 1) ? PIPE_STAGES - 1 : 1;

  // Prefix-tree state carried between stages; cin is pre-folded into g[0],
  // so every group anchored at bit 0 yields the true carry out of its MSB.
  typedef struct packed {
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] p0;
    logic             cin;
  } pp_t;

  // One Brent-Kung level: up-sweep for lvl < LOGW, then down-sweep.
  function automatic pp_t apply_level(input int unsigned lvl, input pp_t x);
    pp_t         y;
    int unsigned span;
    logic        up;
    logic        hit;
    y    = x;
    up   = (lvl < LOGW);
    span = up ? (32'd1 << lvl) : (32'd1 << (2 * LOGW - 2 - lvl));
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (up) hit = ((i + 1) % (2 * span) == 0);
      else    hit = ((i + 1) % (2 * span) == span) && (i + 1 > 2 * span);
      if (hit) begin
        y.g[i] = x.g[i] | (x.p[i] & x.g[i - span]);
        y.p[i] = x.p[i] & x.p[i - span];
      end
    end
    return y;
  endfunction

  pp_t                   pl_q [NMID];
  pp_t                   pl_d [NMID];
  pp_t                   fin;
  logic [WIDTH-1:0]      sum_c, sum_q;
  logic                  cout_c, cout_q, ovf_c, ovf_q;
  logic [PIPE_STAGES-1:0] v_q, v_d, v_in, rdy;

  // Front-end generate/propagate plus the prefix levels assigned to each stage.
  always_comb begin : datapath
    pp_t              cur;
    logic [WIDTH-1:0] bx;
    logic             c0;
    bx        = sub ? ~b : b;
    c0        = sub | cin;
    cur.p0    = a ^ bx;
    cur.p     = cur.p0;
    cur.g     = a & bx;
    cur.cin   = c0;
    cur.g[0]  = cur.g[0] | (cur.p0[0] & c0);
    for (int unsigned k = 0; k < NMID; k++) pl_d[k] = pl_q[k];
    fin = cur;
    for (int unsigned s = 0; s < PIPE_STAGES; s++) begin
      if (s > 0) cur = pl_q[(s > 0) ? s - 1 : 0];
      for (int unsigned l = s * LEVELS / PIPE_STAGES; l < (s + 1) * LEVELS / PIPE_STAGES; l++)
        cur = apply_level(l, cur);
      if (s + 1 < PIPE_STAGES) pl_d[(s + 1 < PIPE_STAGES) ? s : 0] = cur;
      else                     fin = cur;
    end
  end

  // Final sum/flags from the completed carry vector.
  always_comb begin : result
    logic [WIDTH-1:0] wrap_c;
    wrap_c = fin.p0 ^ {fin.g[WIDTH-2:0], fin.cin};
    cout_c = fin.g[WIDTH-1];
    ovf_c  = fin.g[WIDTH-1] ^ fin.g[WIDTH-2];
`ifdef BRENT_ADDER_SAT_EN
    // A wrapped negative result means the true result was positive.
    if (ovf_c) sum_c = wrap_c[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
    else       sum_c = wrap_c;
`else
    sum_c = wrap_c;
`endif
  end

  // Stage k can load unless it and every stage after it are full with the
  // consumer stalled; this collapses bubbles under backpressure.
  always_comb begin : handshake
    v_in[0] = in_valid;
    for (int unsigned k = 1; k < PIPE_STAGES; k++) v_in[k] = v_q[k-1];
    for (int unsigned k = 0; k < PIPE_STAGES; k++) begin
      rdy[k] = out_ready | ~(&(v_q | ~({PIPE_STAGES{1'b1}} << k)));
      v_d[k] = rdy[k] ? v_in[k] : v_q[k];
    end
  end

  assign in_ready = rdy[0];

  // Valid bits and output registers.
  always_ff @(posedge clk) begin : ctrl_regs
    if (reset) begin
      v_q    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      v_q <= v_d;
      if (rdy[PIPE_STAGES-1] && v_in[PIPE_STAGES-1]) begin
        sum_q  <= sum_c;
        cout_q <= cout_c;
        ovf_q  <= ovf_c;
      end
    end
  end

  // Intermediate prefix registers; contents are qualified by v_q.
  always_ff @(posedge clk) begin : mid_regs
    for (int unsigned k = 0; k + 1 < PIPE_STAGES; k++)
      if (rdy[k] && v_in[k]) pl_q[k] <= pl_d[k];
  end

  assign out_valid = v_q[PIPE_STAGES-1];
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule
